// File: rtl/gelu_param_sched_if.sv
// rtl/gelu_param_sched_if.sv - stream bundle (tdata/tvalid/tready/tlast) used by gelu_param_sched
interface gelu_param_sched_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
  modport tap    (input tdata, input tvalid, input tlast, input tready);
endinterface

// File: rtl/gelu_param_sched.sv
// rtl/gelu_param_sched.sv - GELU per-layer parameter router and layer/batch sequencer
// Optional framing check on s_param tlast enabled by defining PARAM_CHECK_EN.
module gelu_param_sched #(
  parameter  int X_W          = 32,
  parameter  int MATRIXSIZE_W = 16,
  parameter  int LAYERS       = 12,
  parameter  int BATCHES      = 1,
  localparam int LW           = (LAYERS  > 1) ? $clog2(LAYERS)  : 1,
  localparam int BW           = (BATCHES > 1) ? $clog2(BATCHES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] cfg_m3,
  gelu_param_sched_if.slave       s_param,
  gelu_param_sched_if.master      m_bias,
  gelu_param_sched_if.master      m_m,
  gelu_param_sched_if.master      m_e,
  gelu_param_sched_if.tap         mon,
  output logic [LW-1:0]           layer_idx,
  output logic [BW-1:0]           batch_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    param_err
);

  typedef enum logic [2:0] {IDLE, LOAD_B, LOAD_M, LOAD_E, RUN, DONE} state_t;

  state_t                  state;
  logic [MATRIXSIZE_W-1:0] m3_q;
  logic [MATRIXSIZE_W-1:0] beat;
  logic [MATRIXSIZE_W-1:0] last_beat;
  logic                    bias_last;
  logic                    p_fire;
  logic                    mon_fire;
  logic                    frame_err;

  assign last_beat = m3_q - MATRIXSIZE_W'(1);
  assign bias_last = (beat == last_beat);

  // Zero-latency routing: the active load state owns the param stream outright.
  always_comb begin
    m_bias.tvalid  = 1'b0;
    m_m.tvalid     = 1'b0;
    m_e.tvalid     = 1'b0;
    s_param.tready = 1'b0;
    case (state)
      LOAD_B: begin
        m_bias.tvalid  = s_param.tvalid;
        s_param.tready = m_bias.tready;
      end
      LOAD_M: begin
        m_m.tvalid     = s_param.tvalid;
        s_param.tready = m_m.tready;
      end
      LOAD_E: begin
        m_e.tvalid     = s_param.tvalid;
        s_param.tready = m_e.tready;
      end
      default: ;
    endcase
  end

  assign m_bias.tdata = s_param.tdata;
  assign m_m.tdata    = s_param.tdata;
  assign m_e.tdata    = s_param.tdata;
  assign m_bias.tlast = (state == LOAD_B) && bias_last;
  assign m_m.tlast    = 1'b1;
  assign m_e.tlast    = 1'b1;

  assign p_fire   = s_param.tvalid && s_param.tready;
  assign mon_fire = mon.tvalid && mon.tready && mon.tlast;

`ifdef PARAM_CHECK_EN
  // Input tlast must sit only on the e word; sequencing still follows the beat count.
  assign frame_err = p_fire && ((((state == LOAD_B) || (state == LOAD_M)) && s_param.tlast) ||
                                ((state == LOAD_E) && !s_param.tlast));
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      m3_q      <= '0;
      beat      <= '0;
      layer_idx <= '0;
      batch_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      param_err <= 1'b0;
    end else begin
      if (frame_err) param_err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            param_err <= 1'b0;
            layer_idx <= '0;
            batch_idx <= '0;
            beat      <= '0;
            m3_q      <= cfg_m3;
            state     <= (cfg_m3 == '0) ? LOAD_M : LOAD_B;
          end
        end
        LOAD_B: begin
          if (p_fire) begin
            if (bias_last) begin
              beat  <= '0;
              state <= LOAD_M;
            end else begin
              beat <= beat + MATRIXSIZE_W'(1);
            end
          end
        end
        LOAD_M: if (p_fire) state <= LOAD_E;
        LOAD_E: if (p_fire) state <= RUN;
        RUN: begin
          if (mon_fire) begin
            if (batch_idx == BW'(BATCHES - 1)) begin
              batch_idx <= '0;
              if (layer_idx == LW'(LAYERS - 1)) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                layer_idx <= layer_idx + LW'(1);
                state     <= (m3_q == '0) ? LOAD_M : LOAD_B;
              end
            end else begin
              batch_idx <= batch_idx + BW'(1);
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          layer_idx <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
